// File: rtl/dispatch_queue.sv
// dispatch_queue: multi-push multi-pop circular FIFO with all-or-nothing push admission
module dispatch_queue #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 8,
  parameter int PUSH_N = 4,
  parameter int POP_N  = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flash,
  input  logic                           stall,
  input  logic [PUSH_N*DATA_W-1:0]       in_data,
  input  logic [$clog2(PUSH_N+1)-1:0]    in_num,
  input  logic [$clog2(POP_N+1)-1:0]     pop_num,
  output logic [POP_N*DATA_W-1:0]        out_data,
  output logic [POP_N-1:0]               out_valid,
  output logic [$clog2(DEPTH+1)-1:0]     size,
  output logic [$clog2(DEPTH+1)-1:0]     size_left,
  output logic                           push_reject
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(PUSH_N + 1);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count, push_cnt, pop_cnt;
  assign size        = count;
  assign size_left   = CW'(DEPTH) - count;
  assign push_reject = CW'(in_num) > size_left;
  assign push_cnt    = push_reject ? '0 : CW'(in_num);
  assign pop_cnt     = stall ? '0 : ((CW'(pop_num) < count) ? CW'(pop_num) : count);
  for (genvar k = 0; k < POP_N; k++) begin : g_out
    assign out_valid[k]                  = CW'(k) < count;
    assign out_data[k*DATA_W +: DATA_W]  = out_valid[k] ? mem[head + PW'(k)] : '0;
  end
  always_ff @(posedge clk)
    for (int i = 0; i < PUSH_N; i++)
      if (!rst && !flash && !push_reject && IW'(i) < in_num)
        mem[tail + PW'(i)] <= in_data[i*DATA_W +: DATA_W];
  always_ff @(posedge clk)
    if (rst || flash) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(pop_cnt);
      tail  <= tail + PW'(push_cnt);
      count <= count + push_cnt - pop_cnt;
    end
endmodule

// File: tb/tb_dispatch_queue.sv
// tb_dispatch_queue: directed vector table, wrap sequence and randomized run against a queue model
module tb_dispatch_queue;
  localparam int DW = 32, DEPTH = 8, PUSH_N = 4, POP_N = 2;
  logic clk, rst, flash, stall;
  logic [PUSH_N*DW-1:0] in_data;
  logic [2:0] in_num;
  logic [1:0] pop_num;
  logic [POP_N*DW-1:0] out_data;
  logic [POP_N-1:0] out_valid;
  logic [3:0] size, size_left;
  logic push_reject;
  int checks = 0, failures = 0;
  int unsigned seq = 0;
  int unsigned q[$];
  typedef struct {
    logic r, fl, st;
    int   num, pop;
    logic rej;
    int   sz;
  } vec_t;
  vec_t vt[$];

  dispatch_queue #(.DATA_W(DW), .DEPTH(DEPTH), .PUSH_N(PUSH_N), .POP_N(POP_N)) dut (
    .clk(clk), .rst(rst), .flash(flash), .stall(stall), .in_data(in_data),
    .in_num(in_num), .pop_num(pop_num), .out_data(out_data), .out_valid(out_valid),
    .size(size), .size_left(size_left), .push_reject(push_reject)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  always @(negedge clk)
    assert (in_num <= PUSH_N && pop_num <= POP_N)
      else $error("FAIL illegal_input in_num=%0d pop_num=%0d", in_num, pop_num);

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic drive(logic r, logic fl, logic st, int num, int pop, bit rnd);
    rst = r; flash = fl; stall = st; in_num = 3'(num); pop_num = 2'(pop);
    for (int i = 0; i < PUSH_N; i++)
      in_data[i*DW +: DW] = rnd ? $urandom : 32'hA000_0000 + seq + i;
    seq += num;
  endtask

  task automatic step();
    int sz, pe;
    logic [63:0] ed;
    logic [1:0] ev;
    @(negedge clk);
    sz = q.size();
    ed = '0; ev = '0;
    for (int k = 0; k < POP_N; k++)
      if (k < sz) begin
        ev[k] = 1'b1;
        ed[k*DW +: DW] = q[k];
      end
    chk("size", 64'(size), 64'(sz));
    chk("size_left", 64'(size_left), 64'(DEPTH - sz));
    chk("push_reject", 64'(push_reject), 64'(int'(in_num) > DEPTH - sz));
    chk("out_valid", 64'(out_valid), 64'(ev));
    chk("out_data", out_data, ed);
    if (rst || flash) q.delete();
    else begin
      pe = stall ? 0 : (int'(pop_num) < sz ? int'(pop_num) : sz);
      repeat (pe) void'(q.pop_front());
      if (int'(in_num) <= DEPTH - sz)
        for (int i = 0; i < int'(in_num); i++) q.push_back(in_data[i*DW +: DW]);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    vt.push_back('{1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 0});
    vt.push_back('{1'b0, 1'b0, 1'b0, 4, 0, 1'b0, 4});
    vt.push_back('{1'b0, 1'b0, 1'b0, 2, 0, 1'b0, 6});
    vt.push_back('{1'b0, 1'b0, 1'b0, 3, 2, 1'b1, 4});
    vt.push_back('{1'b0, 1'b0, 1'b0, 0, 2, 1'b0, 2});
    vt.push_back('{1'b0, 1'b0, 1'b0, 0, 1, 1'b0, 1});
    vt.push_back('{1'b0, 1'b0, 1'b1, 0, 2, 1'b0, 1});
    vt.push_back('{1'b0, 1'b0, 1'b0, 0, 2, 1'b0, 0});
    vt.push_back('{1'b0, 1'b0, 1'b0, 0, 2, 1'b0, 0});
    vt.push_back('{1'b0, 1'b0, 1'b0, 4, 0, 1'b0, 4});
    vt.push_back('{1'b0, 1'b0, 1'b0, 1, 0, 1'b0, 5});
    vt.push_back('{1'b0, 1'b1, 1'b0, 2, 2, 1'b0, 0});
    vt.push_back('{1'b0, 1'b0, 1'b0, 4, 0, 1'b0, 4});
    vt.push_back('{1'b0, 1'b0, 1'b0, 4, 0, 1'b0, 8});
    vt.push_back('{1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 8});
    vt.push_back('{1'b0, 1'b0, 1'b0, 1, 0, 1'b1, 8});
    vt.push_back('{1'b0, 1'b0, 1'b0, 1, 2, 1'b1, 6});
    vt.push_back('{1'b1, 1'b0, 1'b0, 4, 1, 1'b1, 0});
    foreach (vt[j]) begin
      drive(vt[j].r, vt[j].fl, vt[j].st, vt[j].num, vt[j].pop, 0);
      #1;
      chk($sformatf("vec%0d_rej", j), 64'(push_reject), 64'(vt[j].rej));
      step();
      chk($sformatf("vec%0d_size", j), 64'(size), 64'(vt[j].sz));
    end
    drive(0, 0, 0, 0, 0, 0);
    step();
    chk("post_reset_data", out_data, 64'h0);
    drive(0, 0, 0, 4, 0, 0);
    step();
    for (int c = 0; c < 20; c++) begin
      drive(0, 0, 0, 2, 2, 0);
      step();
      chk("wrap_le8", 64'(size <= 4'd8), 64'd1);
    end
    repeat (3) begin
      drive(0, 0, 0, 0, 2, 0);
      step();
    end
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(0, 99) == 0, $urandom_range(0, 99) < 3, $urandom_range(0, 9) == 0,
            $urandom_range(0, PUSH_N), $urandom_range(0, POP_N), 1);
      step();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dispatch_queue.md
DISPATCH_QUEUE -- requirements
Module: dispatch_queue

Interface
REQ-001 The block SHALL have parameter DATA_W, default 64, meaning the bit width of one queue element.
REQ-002 The block SHALL have parameter DEPTH, default 8, meaning the entry count; it is a power of two and at least max(PUSH_N, POP_N).
REQ-003 The block SHALL have parameter PUSH_N, default 4, meaning the maximum pushes per cycle.
REQ-004 The block SHALL have parameter POP_N, default 2, meaning the maximum pops per cycle.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-007 The block SHALL have port flash, input, 1 bit: discard all queue contents.
REQ-008 The block SHALL have port stall, input, 1 bit: suppress pops this cycle.
REQ-009 The block SHALL have port in_data, input, PUSH_N x DATA_W bits: push lanes, packed from lane 0.
REQ-010 The block SHALL have port in_num, input, clog2(PUSH_N+1) bits: number of valid push lanes.
REQ-011 The block SHALL have port pop_num, input, clog2(POP_N+1) bits: number of entries the consumer takes.
REQ-012 The block SHALL have port out_data, output, POP_N x DATA_W bits: the oldest POP_N entries, lane 0 = head.
REQ-013 The block SHALL have port out_valid, output, POP_N bits: lane k holds a real entry.
REQ-014 The block SHALL have port size, output, clog2(DEPTH+1) bits: current occupancy.
REQ-015 The block SHALL have port size_left, output, clog2(DEPTH+1) bits: DEPTH - size.
REQ-016 The block SHALL have port push_reject, output, 1 bit: this cycle's push is refused.

Function
REQ-017 Storage SHALL be a circular buffer with head and tail pointers of clog2(DEPTH) bits that wrap modulo DEPTH, plus a registered count.
REQ-018 out_data lane k SHALL equal entry (head+k) mod DEPTH, combinationally from storage; out_valid[k] = (k < size).
REQ-019 Lanes with out_valid low SHALL drive out_data as zero.
REQ-020 size and size_left SHALL be driven directly from registered count, with no combinational path from inputs.
REQ-021 push_reject SHALL be combinational, asserted when in_num > size_left, where size_left is the pre-pop value.
REQ-022 Push SHALL be all-or-nothing: when push_reject = 1 no lane is written and tail is unchanged; otherwise lanes 0..in_num-1 are written at tail..tail+in_num-1 (mod DEPTH) and tail advances by in_num.
REQ-023 Effective pop SHALL be 0 if stall = 1; otherwise min(pop_num, size). Requests beyond occupancy are clamped, never underflowing.
REQ-024 head SHALL advance by the effective pop.
REQ-025 Next count SHALL equal count + accepted push - effective pop; simultaneous push and pop in one cycle is legal.
REQ-026 Freed slots SHALL NOT be reused by a same-cycle push, because push admission uses pre-pop size_left.
REQ-027 Latency: an entry pushed in cycle N SHALL appear on out_data with out_valid in cycle N+1 at the earliest; no push-to-pop bypass.
REQ-028 An in_num value greater than PUSH_N or a pop_num value greater than POP_N is illegal input; behaviour is undefined, and the bench asserts against it.
REQ-029 flash = 1 SHALL set head = tail = 0 and count = 0 at the next edge; flash overrides push and pop in the same cycle, and push_reject is ignored.
REQ-030 Entry storage SHALL NOT require clearing on flash or reset; only pointers and count are cleared.
REQ-031 Full (size = DEPTH): any in_num > 0 SHALL be rejected; in_num = 0 SHALL NOT assert push_reject.
REQ-032 Empty (size = 0): out_valid SHALL be all zero and pop_num SHALL be ignored.

Reset
REQ-033 While rst = 1 at a clock edge, head, tail and count SHALL become 0; rst has priority over flash, push and pop.
REQ-034 After reset, the outputs SHALL be size = 0, size_left = DEPTH, out_valid = 0, out_data = 0, and push_reject = (in_num > DEPTH), which is 0 for legal in_num.
REQ-035 Reset asserted mid-operation SHALL discard all entries, with behaviour identical to power-on reset.

Verification (DEPTH=8, PUSH_N=4, POP_N=2, DATA_W=32)
REQ-036 The bench SHALL cover: reset, then push 4 lanes A..D -> next cycle size=4, size_left=4, out_data={A,B}, out_valid=2'b11.
REQ-037 The bench SHALL cover: with size=6, push in_num=3 with pop_num=2 -> push_reject=1, next size=4, head entry advanced by 2.
REQ-038 The bench SHALL cover: wrap-around, by filling and draining 2 per cycle across 20 cycles -> FIFO order preserved across the pointer wrap at 7->0, and size never exceeds 8.
REQ-039 The bench SHALL cover: size=1, pop_num=2 -> effective pop 1, next size=0, out_valid=0; with stall=1 instead -> size stays 1.
REQ-040 The bench SHALL cover: size=5, flash=1 with in_num=2 and pop_num=2 -> next size=0, size_left=8, out_valid=0.
REQ-041 The bench SHALL cover: size=8, in_num=0 -> push_reject=0; in_num=1 -> push_reject=1, contents unchanged.
